rv_wb_arbiter: RTL and testbench

Shares the register-file write port between the in-order pipeline write stage and a long-latency unit (LLU, e.g. multiply/divide) that returns results out of band. Pipeline writes always win. LLU results wait in a small pending FIFO and drain into idle write slots. A 32-entry scoreboard tracks destinations with LLU results outstanding, and a starvation counter requests a pipeline bubble when an LLU result has waited too long. Sits between the write stage and the register file; decode consumes the hazard output.

---
 rtl/rv_wb_arbiter.sv | 133 +++++++++++++
 tb/tb_rv_wb_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writes win, long-latency results queue in a small
// FIFO and drain into idle slots; a scoreboard flags pending destinations to decode.
module rv_wb_arbiter #(
    parameter int unsigned PEND_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_pipe_write,
    input  logic [4:0]  i_pipe_rd,
    input  logic [31:0] i_pipe_data,
    input  logic        i_llu_valid,
    input  logic [4:0]  i_llu_rd,
    input  logic [31:0] i_llu_data,
    output logic        o_llu_ready,
    input  logic        i_llu_issue,
    input  logic [4:0]  i_llu_issue_rd,
    input  logic [4:0]  i_q_rs1,
    input  logic [4:0]  i_q_rs2,
    input  logic [4:0]  i_q_rd,
    output logic        o_hazard,
    output logic        o_stall,
    output logic        o_write_op,
    output logic [4:0]  o_rd,
    output logic [31:0] o_data
);
    localparam int unsigned PtrW = $clog2(PEND_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(PEND_DEPTH);
    localparam logic [StW-1:0]  StMax   = StW'(STARVE_LIMIT);

    logic [4:0]      fifo_rd_q   [PEND_DEPTH];
    logic [31:0]     fifo_data_q [PEND_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic [31:0]     busy_q, busy_d;
    logic            write_q, write_d;
    logic            src_llu_q, src_llu_d;
    logic [4:0]      rd_q, rd_d;
    logic [31:0]     data_q, data_d;

    logic pipe_used, fifo_empty, fifo_full, push, pop;

    always_comb begin
        pipe_used  = i_pipe_write & (i_pipe_rd != 5'd0);
        fifo_empty = (cnt_q == '0);
        fifo_full  = (cnt_q == CntFull);
        // x0 results are accepted but never stored
        push       = i_llu_valid & ~fifo_full & (i_llu_rd != 5'd0);
        pop        = ~pipe_used & ~fifo_empty;
    end

    always_comb begin
        wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop  ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q + CntW'(push) - CntW'(pop);

        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (starve_q != StMax) begin
            starve_d = starve_q + StW'(1);
        end else begin
            starve_d = starve_q;
        end

        write_d   = 1'b0;
        src_llu_d = 1'b0;
        rd_d      = rd_q;
        data_d    = data_q;
        if (pipe_used) begin
            write_d = 1'b1;
            rd_d    = i_pipe_rd;
            data_d  = i_pipe_data;
        end else if (pop) begin
            write_d   = 1'b1;
            src_llu_d = 1'b1;
            rd_d      = fifo_rd_q[rptr_q];
            data_d    = fifo_data_q[rptr_q];
        end

        // Clear first so a same-edge issue to the same register keeps it busy
        busy_d = busy_q;
        if (write_q && src_llu_q) begin
            busy_d[rd_q] = 1'b0;
        end
        if (i_llu_issue && (i_llu_issue_rd != 5'd0)) begin
            busy_d[i_llu_issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            starve_q  <= '0;
            busy_q    <= '0;
            write_q   <= 1'b0;
            src_llu_q <= 1'b0;
            rd_q      <= '0;
            data_q    <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            busy_q    <= busy_d;
            write_q   <= write_d;
            src_llu_q <= src_llu_d;
            rd_q      <= rd_d;
            data_q    <= data_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_rd_q[wptr_q]   <= i_llu_rd;
            fifo_data_q[wptr_q] <= i_llu_data;
        end
    end

    assign o_llu_ready = ~fifo_full;
    assign o_hazard    = busy_q[i_q_rs1] | busy_q[i_q_rs2] | busy_q[i_q_rd];
    assign o_stall     = (starve_q == StMax);
    assign o_write_op  = write_q;
    assign o_rd        = rd_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Bench for rv_wb_arbiter: directed vector table, hand sequences for starvation and reset,
// and randomized traffic checked against a queue-based reference model.
module tb_rv_wb_arbiter;
    localparam int unsigned PEND_DEPTH   = 2;
    localparam int unsigned STARVE_LIMIT = 8;

    typedef struct {
        logic        rst_n;
        logic        pw;
        logic [4:0]  prd;
        logic [31:0] pdata;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldata;
        logic        iss;
        logic [4:0]  ird;
        logic [4:0]  q1, q2, q3;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        rdy, stl, hz;
    } vec_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset_n, pipe_write, llu_valid, llu_ready, llu_issue;
    logic [4:0]  pipe_rd, llu_rd, llu_issue_rd, q_rs1, q_rs2, q_rd;
    logic [31:0] pipe_data, llu_data;
    logic        hazard, stall, write_op;
    logic [4:0]  rd;
    logic [31:0] data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    ent_t        m_fifo[$];
    logic [31:0] m_busy = '0;
    int          m_wait = 0;
    logic        m_wr = 1'b0, m_src = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    stim_t       cur;

    always #5 clk = ~clk;

    rv_wb_arbiter #(
        .PEND_DEPTH  (PEND_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_pipe_write  (pipe_write),
        .i_pipe_rd     (pipe_rd),
        .i_pipe_data   (pipe_data),
        .i_llu_valid   (llu_valid),
        .i_llu_rd      (llu_rd),
        .i_llu_data    (llu_data),
        .o_llu_ready   (llu_ready),
        .i_llu_issue   (llu_issue),
        .i_llu_issue_rd(llu_issue_rd),
        .i_q_rs1       (q_rs1),
        .i_q_rs2       (q_rs2),
        .i_q_rd        (q_rd),
        .o_hazard      (hazard),
        .o_stall       (stall),
        .o_write_op    (write_op),
        .o_rd          (rd),
        .o_data        (data)
    );

    function automatic stim_t mk(input logic rst_n, input logic pw, input logic [4:0] prd,
                                 input logic [31:0] pd, input logic lv, input logic [4:0] lrd,
                                 input logic [31:0] ld, input logic iss, input logic [4:0] ird,
                                 input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3);
        stim_t s;
        s.rst_n = rst_n; s.pw = pw; s.prd = prd; s.pdata = pd;
        s.lv = lv; s.lrd = lrd; s.ldata = ld; s.iss = iss; s.ird = ird;
        s.q1 = q1; s.q2 = q2; s.q3 = q3;
        return s;
    endfunction

    function automatic vec_t mkv(input stim_t s, input logic wr, input logic [4:0] r,
                                 input logic [31:0] d, input logic rdy, input logic stl,
                                 input logic hz);
        vec_t v;
        v.s = s; v.wr = wr; v.rd = r; v.data = d; v.rdy = rdy; v.stl = stl; v.hz = hz;
        return v;
    endfunction

    function automatic stim_t idle(input logic [4:0] q1, input logic [4:0] q2,
                                   input logic [4:0] q3);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2, q3);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural rules applied at one clock edge, using pre-edge model state
    task automatic model_step(input stim_t s);
        bit   pipe_used, popped;
        int   sz;
        ent_t e;
        if (!s.rst_n) begin
            m_fifo.delete();
            m_busy = '0; m_wait = 0; m_wr = 0; m_src = 0; m_rd = '0; m_data = '0;
        end else begin
            sz        = m_fifo.size();
            pipe_used = s.pw && (s.prd != 0);
            popped    = !pipe_used && (sz > 0);
            if (m_wr && m_src) m_busy[m_rd] = 1'b0;
            if (s.iss && s.ird != 0) m_busy[s.ird] = 1'b1;
            if (popped || sz == 0) m_wait = 0;
            else if (m_wait < int'(STARVE_LIMIT)) m_wait++;
            if (pipe_used) begin
                m_wr = 1; m_src = 0; m_rd = s.prd; m_data = s.pdata;
            end else if (popped) begin
                e = m_fifo.pop_front();
                m_wr = 1; m_src = 1; m_rd = e.rd; m_data = e.data;
            end else begin
                m_wr = 0; m_src = 0;
            end
            if (s.lv && sz < int'(PEND_DEPTH) && s.lrd != 0) m_fifo.push_back({s.lrd, s.ldata});
        end
    endtask

    task automatic step(input stim_t s);
        @(negedge clk);
        cur          = s;
        reset_n      = s.rst_n;
        pipe_write   = s.pw;
        pipe_rd      = s.prd;
        pipe_data    = s.pdata;
        llu_valid    = s.lv;
        llu_rd       = s.lrd;
        llu_data     = s.ldata;
        llu_issue    = s.iss;
        llu_issue_rd = s.ird;
        q_rs1        = s.q1;
        q_rs2        = s.q2;
        q_rd         = s.q3;
        @(posedge clk);
        model_step(s);
        #1;
        chk("model_wr", write_op, m_wr);
        chk("model_rd", rd, m_rd);
        chk("model_data", data, m_data);
        chk("model_ready", llu_ready, m_fifo.size() < int'(PEND_DEPTH));
        chk("model_stall", stall, m_wait == int'(STARVE_LIMIT));
        chk("model_hazard", hazard, m_busy[cur.q1] | m_busy[cur.q2] | m_busy[cur.q3]);
    endtask

    vec_t  tbl[14];
    stim_t rs;
    int    pw_pct;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        reset_n = 0; pipe_write = 0; pipe_rd = 0; pipe_data = 0;
        llu_valid = 0; llu_rd = 0; llu_data = 0; llu_issue = 0; llu_issue_rd = 0;
        q_rs1 = 0; q_rs2 = 0; q_rd = 0;

        // Each entry: inputs held for one cycle, outputs expected in the following cycle
        tbl[0]  = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 0, 0);
        tbl[1]  = mkv(mk(1, 1, 3, 32'h11, 1, 7, 32'hAA, 0, 0, 0, 0, 0), 1, 3, 32'h11, 1, 0, 0);
        tbl[2]  = mkv(idle(0, 0, 0), 1, 7, 32'hAA, 1, 0, 0);
        tbl[3]  = mkv(mk(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0, 0), 0, 7, 32'hAA, 1, 0, 1);
        tbl[4]  = mkv(mk(1, 0, 0, 0, 1, 9, 32'h1234, 0, 0, 9, 0, 0), 0, 7, 32'hAA, 1, 0, 1);
        tbl[5]  = mkv(idle(9, 0, 0), 1, 9, 32'h1234, 1, 0, 1);
        tbl[6]  = mkv(idle(9, 0, 0), 0, 9, 32'h1234, 1, 0, 0);
        tbl[7]  = mkv(mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 4), 0, 9, 32'h1234, 1, 0, 1);
        tbl[8]  = mkv(mk(1, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, 4), 0, 9, 32'h1234, 1, 0, 1);
        tbl[9]  = mkv(idle(0, 0, 4), 1, 4, 32'h44, 1, 0, 1);
        tbl[10] = mkv(mk(1, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 4), 0, 4, 32'h44, 1, 0, 1);
        tbl[11] = mkv(idle(0, 0, 4), 0, 4, 32'h44, 1, 0, 1);
        tbl[12] = mkv(mk(1, 1, 0, 32'hFF, 1, 0, 32'h55, 0, 0, 0, 0, 4), 0, 4, 32'h44, 1, 0, 1);
        tbl[13] = mkv(idle(0, 0, 4), 0, 4, 32'h44, 1, 0, 1);

        for (int i = 0; i < 14; i++) begin
            step(tbl[i].s);
            chk($sformatf("vec%0d_wr", i), write_op, tbl[i].wr);
            chk($sformatf("vec%0d_rd", i), rd, tbl[i].rd);
            chk($sformatf("vec%0d_data", i), data, tbl[i].data);
            chk($sformatf("vec%0d_ready", i), llu_ready, tbl[i].rdy);
            chk($sformatf("vec%0d_stall", i), stall, tbl[i].stl);
            chk($sformatf("vec%0d_hazard", i), hazard, tbl[i].hz);
        end

        // Starvation: pipe busy every cycle while three results arrive
        for (int c = 0; c <= 8; c++) begin
            if (c == 0)      step(mk(1, 1, 1, c, 1, 10, 32'hA0, 0, 0, 0, 0, 0));
            else if (c == 1) step(mk(1, 1, 1, c, 1, 11, 32'hB0, 0, 0, 0, 0, 0));
            else             step(mk(1, 1, 1, c, 1, 12, 32'hC0, 0, 0, 0, 0, 0));
            if (c >= 2) chk("starve_ready_low", llu_ready, 1'b0);
            if (c == 7) chk("starve_stall_pre", stall, 1'b0);
            if (c == 8) chk("starve_stall_hit", stall, 1'b1);
        end
        step(mk(1, 0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0));
        chk("bubble_rd", rd, 5'd10);
        chk("bubble_data", data, 32'hA0);
        chk("bubble_stall", stall, 1'b0);
        chk("bubble_ready", llu_ready, 1'b1);
        step(mk(1, 0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0));
        chk("drain_b", rd, 5'd11);
        step(idle(0, 0, 0));
        chk("drain_c", rd, 5'd12);
        chk("drain_c_data", data, 32'hC0);
        step(idle(0, 0, 0));

        // Reset with a full FIFO, busy[5] and a partly advanced starvation counter
        step(mk(1, 1, 1, 1, 1, 20, 32'h20, 1, 5, 0, 0, 0));
        step(mk(1, 1, 2, 2, 1, 21, 32'h21, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) step(mk(1, 1, 3, 3, 0, 0, 0, 0, 0, 5, 0, 0));
        chk("prerst_ready", llu_ready, 1'b0);
        chk("prerst_hazard", hazard, 1'b1);
        step(mk(0, 1, 4, 4, 1, 22, 32'h22, 1, 6, 5, 6, 0));
        chk("rst_wr", write_op, 1'b0);
        chk("rst_rd", rd, 5'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_ready", llu_ready, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_hazard", hazard, 1'b0);
        step(idle(5, 6, 20));
        chk("postrst_wr", write_op, 1'b0);
        chk("postrst_hazard", hazard, 1'b0);

        // Randomized traffic; pipe load alternates between light and heavy phases
        for (int i = 0; i < 400; i++) begin
            pw_pct    = ((i / 50) % 2 == 0) ? 40 : 95;
            rs.rst_n  = ($urandom_range(0, 99) != 0);
            rs.pw     = ($urandom_range(0, 99) < pw_pct);
            rs.prd    = 5'($urandom_range(0, 7));
            rs.pdata  = $urandom;
            rs.lv     = ($urandom_range(0, 1) == 1);
            rs.lrd    = 5'($urandom_range(0, 7));
            rs.ldata  = $urandom;
            rs.iss    = ($urandom_range(0, 3) == 0);
            rs.ird    = 5'($urandom_range(0, 7));
            rs.q1     = 5'($urandom_range(0, 7));
            rs.q2     = 5'($urandom_range(0, 7));
            rs.q3     = 5'($urandom_range(0, 7));
            step(rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
